// File: rtl/adder_pipe_nbits_if.sv
// Operand/result bundle for the pipelined N-bit adder/subtractor.
// o_Valid qualifies o_Sum/o_Cout/o_Ovf; there is no ready, so a consumer that cannot take a result holds the whole pipe with i_En=0.
interface adder_pipe_nbits_if #(
  parameter int WIDTH = 32
);
  logic             i_En;
  logic             i_Flush;
  logic             i_Valid;
  logic             i_Sub;
  logic [WIDTH-1:0] i_A;
  logic [WIDTH-1:0] i_B;
  logic             i_Cin;
  logic             o_Valid;
  logic [WIDTH-1:0] o_Sum;
  logic             o_Cout;
  logic             o_Ovf;

  modport master (
    output i_En, i_Flush, i_Valid, i_Sub, i_A, i_B, i_Cin,
    input  o_Valid, o_Sum, o_Cout, o_Ovf
  );

  modport slave (
    input  i_En, i_Flush, i_Valid, i_Sub, i_A, i_B, i_Cin,
    output o_Valid, o_Sum, o_Cout, o_Ovf
  );
endinterface

// File: rtl/adder_pipe_nbits.sv
// Pipelined N-bit adder/subtractor: the carry chain is cut into STAGES chunks with a
// register level after each; operand bits are skewed in and result bits de-skewed out.
module adder_pipe_nbits #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input logic              i_Clk,
  input logic              i_Rst,
  adder_pipe_nbits_if.slave bus
);
  localparam int CHUNK  = (WIDTH + STAGES - 1) / STAGES;
  localparam int K_LAST = (WIDTH - 1) / CHUNK;
  localparam int NOV    = STAGES - K_LAST;

  logic [WIDTH-1:0]        w_b_in;
  logic [WIDTH-1:0]        w_ad;
  logic [WIDTH-1:0]        w_bd;
  logic [WIDTH-1:0]        w_ci;
  logic [WIDTH-1:0]        w_co;
  logic [WIDTH-1:0]        w_s;
  logic [WIDTH-1:0]        w_sum;
  logic [STAGES-1:0]       w_cy_nx;
  logic                    w_ovf;

  logic [STAGES-1:0]       r_v;
  logic [STAGES-1:0]       r_cy;
  logic [STAGES-1:K_LAST]  r_ov;

  assign w_b_in = bus.i_Sub ? ~bus.i_B : bus.i_B;
  assign w_ovf  = w_ci[WIDTH-1] ^ w_co[WIDTH-1];

  // Bit i belongs to chunk K: its operands wait K cycles, its sum bit waits STAGES-K more.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    localparam int K = i / CHUNK;
    localparam int D = STAGES - K;
    logic [D-1:0] r_sd;

    if (K == 0) begin : g_nodly
      assign w_ad[i] = bus.i_A[i];
      assign w_bd[i] = w_b_in[i];
    end else begin : g_dly
      logic [K-1:0] r_ad;
      logic [K-1:0] r_bd;
      always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
          r_ad <= '0;
          r_bd <= '0;
        end else if (bus.i_En) begin
          r_ad <= K'({r_ad, bus.i_A[i]});
          r_bd <= K'({r_bd, w_b_in[i]});
        end
      end
      assign w_ad[i] = r_ad[K-1];
      assign w_bd[i] = r_bd[K-1];
    end

    if (i % CHUNK == 0) begin : g_cstart
      if (K == 0) begin : g_cin
        assign w_ci[i] = bus.i_Cin;
      end else begin : g_creg
        assign w_ci[i] = r_cy[K-1];
      end
    end else begin : g_cripple
      assign w_ci[i] = w_co[i-1];
    end

    assign w_s[i]  = w_ad[i] ^ w_bd[i] ^ w_ci[i];
    assign w_co[i] = (w_ad[i] & w_bd[i]) | (w_ci[i] & (w_ad[i] ^ w_bd[i]));

    always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
        r_sd <= '0;
      end else if (bus.i_En) begin
        r_sd <= D'({r_sd, w_s[i]});
      end
    end
    assign w_sum[i] = r_sd[D-1];
  end

  // Stages past the last populated chunk just carry the final carry-out along.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * CHUNK;
    if (LO < WIDTH) begin : g_add
      localparam int HI = (((LO + CHUNK) < WIDTH) ? (LO + CHUNK) : WIDTH) - 1;
      assign w_cy_nx[k] = w_co[HI];
    end else begin : g_pass
      assign w_cy_nx[k] = r_cy[k-1];
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_v  <= '0;
      r_cy <= '0;
      r_ov <= '0;
    end else begin
      if (bus.i_Flush) begin
        r_v <= '0;
      end else if (bus.i_En) begin
        r_v <= STAGES'({r_v, bus.i_Valid});
      end
      if (bus.i_En) begin
        r_cy <= w_cy_nx;
        r_ov <= NOV'({r_ov, w_ovf});
      end
    end
  end

  assign bus.o_Valid = r_v[STAGES-1];
  assign bus.o_Sum   = w_sum;
  assign bus.o_Cout  = r_cy[STAGES-1];
  assign bus.o_Ovf   = r_ov[STAGES-1];
endmodule

// File: tb/tb_adder_pipe_nbits.sv
// Bench for adder_pipe_nbits: four configurations share one stimulus stream and are
// checked every cycle against a latency-queue model built on plain arithmetic.
module tb_adder_pipe_nbits;
  localparam int NI = 4;
  localparam int WID [NI] = '{16, 15, 8, 5};
  localparam int DEP [NI] = '{4, 4, 1, 4};

  logic        clk;
  logic        rst;
  logic        en;
  logic        flush;
  logic        valid;
  logic        sub;
  logic        cin;
  logic [15:0] ain;
  logic [15:0] bin;

  int n_tests = 0;
  int n_fail  = 0;

  adder_pipe_nbits_if #(.WIDTH(16)) if16 ();
  adder_pipe_nbits_if #(.WIDTH(15)) if15 ();
  adder_pipe_nbits_if #(.WIDTH(8))  if8  ();
  adder_pipe_nbits_if #(.WIDTH(5))  if5  ();

  adder_pipe_nbits #(.WIDTH(16), .STAGES(4)) u16 (.i_Clk(clk), .i_Rst(rst), .bus(if16));
  adder_pipe_nbits #(.WIDTH(15), .STAGES(4)) u15 (.i_Clk(clk), .i_Rst(rst), .bus(if15));
  adder_pipe_nbits #(.WIDTH(8),  .STAGES(1)) u8  (.i_Clk(clk), .i_Rst(rst), .bus(if8));
  adder_pipe_nbits #(.WIDTH(5),  .STAGES(4)) u5  (.i_Clk(clk), .i_Rst(rst), .bus(if5));

  assign if16.i_En = en;    assign if15.i_En = en;    assign if8.i_En = en;    assign if5.i_En = en;
  assign if16.i_Flush = flush; assign if15.i_Flush = flush; assign if8.i_Flush = flush; assign if5.i_Flush = flush;
  assign if16.i_Valid = valid; assign if15.i_Valid = valid; assign if8.i_Valid = valid; assign if5.i_Valid = valid;
  assign if16.i_Sub = sub;  assign if15.i_Sub = sub;  assign if8.i_Sub = sub;  assign if5.i_Sub = sub;
  assign if16.i_Cin = cin;  assign if15.i_Cin = cin;  assign if8.i_Cin = cin;  assign if5.i_Cin = cin;
  assign if16.i_A = ain;       assign if16.i_B = bin;
  assign if15.i_A = ain[14:0]; assign if15.i_B = bin[14:0];
  assign if8.i_A  = ain[7:0];  assign if8.i_B  = bin[7:0];
  assign if5.i_A  = ain[4:0];  assign if5.i_B  = bin[4:0];

  // Actual outputs as {ovf, cout, sum zero-extended to 16}.
  logic        act_v   [NI];
  logic [17:0] act_res [NI];
  assign act_v[0] = if16.o_Valid; assign act_res[0] = {if16.o_Ovf, if16.o_Cout, if16.o_Sum};
  assign act_v[1] = if15.o_Valid; assign act_res[1] = {if15.o_Ovf, if15.o_Cout, 1'b0, if15.o_Sum};
  assign act_v[2] = if8.o_Valid;  assign act_res[2] = {if8.o_Ovf, if8.o_Cout, 8'd0, if8.o_Sum};
  assign act_v[3] = if5.o_Valid;  assign act_res[3] = {if5.o_Ovf, if5.o_Cout, 11'd0, if5.o_Sum};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Golden w-bit add/sub: returns {ovf, cout, sum}.
  function automatic logic [17:0] golden(input int w, input logic [15:0] a, input logic [15:0] b,
                                         input logic s, input logic c);
    longint unsigned mask, am, bm, t;
    logic ovf;
    mask = (64'd1 << w) - 64'd1;
    am   = {48'd0, a} & mask;
    bm   = {48'd0, (s ? ~b : b)} & mask;
    t    = am + bm + {63'd0, c};
    ovf  = (am[w-1] == bm[w-1]) && (t[w-1] != am[w-1]);
    return {ovf, t[w], 16'(t & mask)};
  endfunction

  // Model: each instance is a DEP-deep queue of pending results that moves on i_En.
  logic        m_v   [NI][4];
  logic [17:0] m_res [NI][4];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < NI; j++)
        for (int d = 0; d < 4; d++) m_v[j][d] <= 1'b0;
    end else if (flush) begin
      for (int j = 0; j < NI; j++)
        for (int d = 0; d < 4; d++) m_v[j][d] <= 1'b0;
    end else if (en) begin
      for (int j = 0; j < NI; j++) begin
        for (int d = 1; d < DEP[j]; d++) begin
          m_v[j][d]   <= m_v[j][d-1];
          m_res[j][d] <= m_res[j][d-1];
        end
        m_v[j][0]   <= valid;
        m_res[j][0] <= golden(WID[j], ain, bin, sub, cin);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int j = 0; j < NI; j++) begin
        n_tests++;
        if (act_v[j] !== m_v[j][DEP[j]-1]) begin
          n_fail++;
          $display("FAIL valid_w%0d t=%0t got %0b want %0b", WID[j], $time, act_v[j], m_v[j][DEP[j]-1]);
        end else if (act_v[j]) begin
          n_tests++;
          if (act_res[j] !== m_res[j][DEP[j]-1]) begin
            n_fail++;
            $display("FAIL result_w%0d t=%0t got %h want %h", WID[j], $time, act_res[j], m_res[j][DEP[j]-1]);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [18:0] got, input logic [18:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h want %h", name, got, exp);
    end
  endtask

  task automatic cyc(input logic e, input logic f, input logic v, input logic s, input logic c,
                     input logic [15:0] a, input logic [15:0] b);
    en = e; flush = f; valid = v; sub = s; cin = c; ain = a; bin = b;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  // Streaming vectors with hand-computed 16-bit {ovf, cout, sum}.
  logic [15:0] sv_a   [6] = '{16'h1234, 16'h8000, 16'h00FF, 16'h1000, 16'h8000, 16'hABCD};
  logic [15:0] sv_b   [6] = '{16'h1111, 16'h8000, 16'h0F01, 16'h0001, 16'h0001, 16'h1234};
  logic        sv_s   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [17:0] sv_exp [6] = '{18'h0_2345, 18'h3_0000, 18'h0_1000, 18'h1_0FFF, 18'h3_7FFF, 18'h0_BE01};

  initial begin
    rst = 1'b1; en = 1'b0; flush = 1'b0; valid = 1'b0; sub = 1'b0; cin = 1'b0; ain = '0; bin = '0;
    repeat (2) @(negedge clk);
    for (int j = 0; j < NI; j++) chk("reset_outputs", {act_v[j], act_res[j]}, 19'h0);
    rst = 1'b0;

    // Full ripple, subtract, signed overflow.
    chk("gold_ripple", {1'b1, golden(16, 16'hFFFF, 16'h0001, 1'b0, 1'b0)}, 19'h5_0000);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h0001); idle(3);
    chk("ripple", {act_v[0], act_res[0]}, 19'h5_0000);
    chk("gold_sub", {1'b1, golden(16, 16'h0005, 16'h0007, 1'b1, 1'b1)}, 19'h4_FFFE);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0005, 16'h0007); idle(3);
    chk("sub_neg", {act_v[0], act_res[0]}, 19'h4_FFFE);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h7FFF, 16'h0001); idle(3);
    chk("ovf_pos", {act_v[0], act_res[0]}, 19'h6_8000);

    // Back-to-back stream with a 3-cycle stall after the second operation.
    for (int i = 0; i < 6; i++) begin
      chk("gold_stream", {1'b1, golden(16, sv_a[i], sv_b[i], sv_s[i], sv_s[i])}, {1'b1, sv_exp[i]});
      cyc(1'b1, 1'b0, 1'b1, sv_s[i], sv_s[i], sv_a[i], sv_b[i]);
      if (i == 1) repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'hDEAD, 16'hBEEF);
    end
    idle(3);
    chk("stream_last", {act_v[0], act_res[0]}, {1'b1, sv_exp[5]});

    // Flush with four in flight; flush is taken even while stalled and with i_Valid high.
    for (int i = 1; i <= 4; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'(i * 16'h0111), 16'(i));
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h5555, 16'h5555);
    chk("flush_clears", {act_v[0], 18'd0}, 19'h0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0F0F, 16'h00F0); idle(3);
    chk("after_flush", {act_v[0], act_res[0]}, 19'h4_1000);

    // Asynchronous reset with three operations in flight.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h4321, 16'(i));
    #2 rst = 1'b1;
    #1;
    for (int j = 0; j < NI; j++) chk("reset_midstream", {act_v[j], act_res[j]}, 19'h0);
    @(negedge clk);
    rst = 1'b0;
    idle(5);
    chk("no_stale", {act_v[0], 18'd0}, 19'h0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0001); idle(3);
    chk("first_after_rst", {act_v[0], act_res[0]}, 19'h4_FFFF);

    // Random regression: all widths, random valid/enable, occasional flush.
    for (int i = 0; i < 1000; i++)
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
    idle(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
